syndrome_sched: RTL
===================

SYNDROME_SCHED -- requirements
Module: syndrome_sched

Interface
REQ-001 Parameter NUM_TP, default 4: number of test patterns per codeword; SHALL be even and >=2.
REQ-002 Parameter NUM_SYN, default 8: syndromes per pattern in full mode; SHALL be even.
REQ-003 Parameter SYN_W, default 10: syndrome width (GF(2^10) symbols).
REQ-004 i_clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 i_rst  in  1  asynchronous, active-high reset.
REQ-006 i_mode  in  1  0 = single pattern, 1 = multi-pattern (Chase).
REQ-007 i_code  in  2  2'b10/2'b11 = full (NUM_SYN per pattern); 2'b00/2'b01 = half (NUM_SYN/2 per pattern).
REQ-008 i_tp_syn  in  NUM_TP*NUM_SYN*SYN_W  flat syndromes; pattern p, syndrome s at bits [(p*NUM_SYN+s)*SYN_W +: SYN_W].
REQ-009 i_valid  in  1 / o_ready  out  1  input handshake; load on i_valid&&o_ready.
REQ-010 i_flush  in  1  synchronous abort.
REQ-011 o_syn  out  NUM_SYN*SYN_W  output beat, slot s at [s*SYN_W +: SYN_W].
REQ-012 o_valid  out  1 / i_ready  in  1  output handshake; beat transfers on o_valid&&i_ready.
REQ-013 o_tp_idx  out  $clog2(NUM_TP)  index of the (lower) pattern in the current beat.
REQ-014 o_last  out  1  high on the final beat of a codeword.
REQ-015 o_zero_mask  out  NUM_TP  bit p = pattern p syndromes all zero.

Function
REQ-016 FSM SHALL have states IDLE and SEND; o_ready SHALL be 1 only in IDLE.
REQ-017 On load, i_tp_syn, i_mode and i_code SHALL be snapshotted into registers; later input changes SHALL NOT affect the codeword in flight.
REQ-018 IDLE->SEND on load; o_valid SHALL rise in the cycle after the load edge (latency 1).
REQ-019 Mode 0: exactly one beat, o_syn = pattern 0 all slots, o_tp_idx=0, o_last=1.
REQ-020 Mode 1 full: NUM_TP beats, beat k = pattern k all slots, o_tp_idx=k.
REQ-021 Mode 1 half: NUM_TP/2 beats; beat k lower NUM_SYN/2 slots = pattern 2k syndromes 0..NUM_SYN/2-1, upper slots = pattern 2k+1 syndromes 0..NUM_SYN/2-1; o_tp_idx=2k.
REQ-022 While o_valid&&!i_ready, o_syn, o_tp_idx, o_last SHALL hold stable.
REQ-023 Beat index SHALL advance only on transfer; transfer of the o_last beat SHALL return FSM to IDLE with o_valid=0 and o_ready=1 next cycle.
REQ-024 i_flush SHALL force IDLE next cycle, o_valid=0, and discard remaining beats; flush SHALL win over simultaneous load or transfer.
REQ-025 o_zero_mask SHALL be registered at load and held until next load; in half mode only syndromes 0..NUM_SYN/2-1 are tested; in mode 0 only bit 0 is evaluated, others 0.

Reset
REQ-026 Asserting i_rst SHALL immediately force IDLE, o_valid=0, o_last=0, o_tp_idx=0, o_syn=0, o_zero_mask=0, beat index 0; o_ready=1 after release.
REQ-027 Reset mid-codeword SHALL drop all pending beats; no beat SHALL be emitted after release without a new load.

Configuration
REQ-028 Macro SYNDROME_SCHED_ZERO_SKIP_EN: when defined, a beat whose patterns are all zero-syndrome (full: that pattern; half: both patterns) SHALL be skipped without a cycle penalty, except the final beat, which is never skipped so o_last framing is preserved.
REQ-029 When undefined, every beat SHALL be emitted and o_zero_mask SHALL read all zeros.

Verification
REQ-030 Mode 0, pattern 0 syndromes 1..8, i_ready=1 -> one beat, o_syn slots 1..8, o_last=1, o_ready=1 two cycles after load.
REQ-031 Mode 1, i_code=2'b10, NUM_TP=4, i_ready toggling 1,0,1,... -> 4 beats, o_tp_idx 0,1,2,3, values stable while stalled, o_last only on idx 3.
REQ-032 Mode 1, i_code=2'b00, pattern p syndrome s = 16p+s -> 2 beats: {0,1,2,3,16,17,18,19} then {32,33,34,35,48,49,50,51}, o_last on beat 2.
REQ-033 Macro defined, full mode, patterns 1 and 2 all zero -> beats idx 0 then 3, o_zero_mask=4'b0110; pattern 3 also zero -> beats idx 0 then 3 (last kept), mask 4'b1110.
REQ-034 Full mode, i_flush asserted during beat idx 1 with i_valid=1 -> o_valid=0 next cycle, no load that cycle, o_ready=1.
REQ-035 i_rst pulsed asynchronously mid beat idx 2 -> outputs zero immediately; after release o_valid stays 0 until new i_valid.

Source files
------------

// File: rtl/syndrome_sched.sv
// syndrome_sched: streams Chase test-pattern syndromes out as fixed-width beats.
// Define SYNDROME_SCHED_ZERO_SKIP_EN to skip all-zero-syndrome beats and report o_zero_mask.
module syndrome_sched #(
  parameter int NUM_TP  = 4,
  parameter int NUM_SYN = 8,
  parameter int SYN_W   = 10
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_mode,
  input  logic [1:0]                        i_code,
  input  logic [NUM_TP*NUM_SYN*SYN_W-1:0]   i_tp_syn,
  input  logic                              i_valid,
  output logic                              o_ready,
  input  logic                              i_flush,
  output logic [NUM_SYN*SYN_W-1:0]          o_syn,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic [$clog2(NUM_TP)-1:0]         o_tp_idx,
  output logic                              o_last,
  output logic [NUM_TP-1:0]                 o_zero_mask
);
  localparam int IDX_W  = $clog2(NUM_TP);
  localparam int TOT_W  = NUM_TP*NUM_SYN*SYN_W;
  localparam int BEAT_W = NUM_SYN*SYN_W;
  localparam int HALF   = NUM_SYN/2;

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state_q, state_d;
  logic [TOT_W-1:0]  tp_q, tp_d;
  logic              mode_q, mode_d;
  logic              half_q, half_d;
  logic [IDX_W-1:0]  beat_q, beat_d;
  logic [BEAT_W-1:0] syn_q, syn_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [NUM_TP-1:0] zmask_q, zmask_d;

  logic              load;
  logic              xfer;
  logic [TOT_W-1:0]  src_tp;
  logic              src_mode;
  logic              src_half;
  int                last_b;
  int                start_b;
  int                nb;
  int                nb_idx;
  logic [BEAT_W-1:0] nb_syn;

`ifdef SYNDROME_SCHED_ZERO_SKIP_EN
  logic [NUM_TP-1:0] zp;
  logic [NUM_TP-1:0] skip;
  logic              found;
`endif

  assign o_ready     = (state_q == IDLE);
  assign o_valid     = valid_q;
  assign o_syn       = syn_q;
  assign o_tp_idx    = idx_q;
  assign o_last      = last_q;
  assign o_zero_mask = zmask_q;

  assign load = (state_q == IDLE) && i_valid;
  assign xfer = valid_q && i_ready;

  // On a load the next beat is built straight from the inputs.
  always_comb begin
    src_tp   = load ? i_tp_syn : tp_q;
    src_mode = load ? i_mode : mode_q;
    src_half = load ? (i_code inside {2'b00, 2'b01}) : half_q;
    last_b   = src_mode ? (src_half ? NUM_TP/2-1 : NUM_TP-1) : 0;
    start_b  = load ? 0 : int'(beat_q) + 1;
    nb       = start_b;
`ifdef SYNDROME_SCHED_ZERO_SKIP_EN
    zp = '1;
    for (int p = 0; p < NUM_TP; p++) begin
      for (int s = 0; s < NUM_SYN; s++) begin
        if ((!src_half || s < HALF) &&
            src_tp[(p*NUM_SYN+s)*SYN_W +: SYN_W] != '0)
          zp[p] = 1'b0;
      end
    end
    skip = '0;
    if (!src_half) skip = zp;
    for (int b = 0; b < NUM_TP/2; b++) begin
      if (src_half) skip[b] = zp[2*b] & zp[2*b+1];
    end
    found = 1'b0;
    for (int b = 0; b < NUM_TP; b++) begin
      if (!found && b >= start_b &&
          (b == last_b || !skip[b])) begin
        nb    = b;
        found = 1'b1;
      end
    end
`endif
    nb_idx = (src_mode && src_half) ? 2*nb : nb;
    nb_syn = '0;
    for (int s = 0; s < NUM_SYN; s++) begin
      if (src_mode && src_half) begin
        if (s < HALF)
          nb_syn[s*SYN_W +: SYN_W] =
            src_tp[((2*nb)*NUM_SYN+s)*SYN_W +: SYN_W];
        else
          nb_syn[s*SYN_W +: SYN_W] =
            src_tp[((2*nb+1)*NUM_SYN+s-HALF)*SYN_W +: SYN_W];
      end else begin
        nb_syn[s*SYN_W +: SYN_W] =
          src_tp[(nb*NUM_SYN+s)*SYN_W +: SYN_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    tp_d    = tp_q;
    mode_d  = mode_q;
    half_d  = half_q;
    beat_d  = beat_q;
    syn_d   = syn_q;
    valid_d = valid_q;
    last_d  = last_q;
    idx_d   = idx_q;
    zmask_d = zmask_q;
    if (i_flush) begin
      state_d = IDLE;
      valid_d = 1'b0;
      last_d  = 1'b0;
      beat_d  = '0;
    end else if (load) begin
      state_d = SEND;
      tp_d    = i_tp_syn;
      mode_d  = i_mode;
      half_d  = src_half;
      valid_d = 1'b1;
      syn_d   = nb_syn;
      idx_d   = IDX_W'(nb_idx);
      last_d  = (nb == last_b);
      beat_d  = IDX_W'(nb);
`ifdef SYNDROME_SCHED_ZERO_SKIP_EN
      zmask_d    = '0;
      zmask_d[0] = zp[0];
      if (src_mode) zmask_d = zp;
`else
      zmask_d = '0;
`endif
    end else if (xfer) begin
      if (last_q) begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end else begin
        syn_d  = nb_syn;
        idx_d  = IDX_W'(nb_idx);
        last_d = (nb == last_b);
        beat_d = IDX_W'(nb);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      tp_q    <= '0;
      mode_q  <= 1'b0;
      half_q  <= 1'b0;
      beat_q  <= '0;
      syn_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      zmask_q <= '0;
    end else begin
      state_q <= state_d;
      tp_q    <= tp_d;
      mode_q  <= mode_d;
      half_q  <= half_d;
      beat_q  <= beat_d;
      syn_q   <= syn_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      zmask_q <= zmask_d;
    end
  end

endmodule
